mips_instr_encoder: RTL

Streaming MIPS instruction encoder that assembles 32-bit instruction words from decoded fields: an operation code plus register, shift, immediate and jump-target operands. It covers the same 20-instruction subset the single-cycle CPU's control unit decodes, but runs in the encode direction. Encoded words are buffered in a small FIFO and emitted with a sequential word address. The block sits between the test/boot program source and the instruction-memory write port.

---
 rtl/mips_instr_encoder.sv | 124 ++++++++++++
 1 files changed

// File: rtl/mips_instr_encoder.sv
// Streaming MIPS encoder: fields -> 32-bit word -> FIFO -> addressed output.
// Optional ENC_ILLEGAL_TRAP_EN drops illegal ops and raises sticky err.
module mips_instr_encoder #(
    parameter int DEPTH = 4,
    parameter int ADDR_W = 8,
    parameter logic [ADDR_W-1:0] BASE_ADDR = '0
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              flush,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [4:0]        in_iop,
    input  logic [4:0]        in_rs,
    input  logic [4:0]        in_rt,
    input  logic [4:0]        in_rd,
    input  logic [4:0]        in_sa,
    input  logic [15:0]       in_imm,
    input  logic [25:0]       in_target,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [31:0]       out_word,
    output logic [ADDR_W-1:0] out_addr,
    output logic              err
);
    localparam int PW = $clog2(DEPTH);

    logic [31:0]       mem [DEPTH];
    logic [PW:0]       wr_ptr;
    logic [PW:0]       rd_ptr;
    logic [ADDR_W-1:0] addr;
    logic [31:0]       word;
    logic              illegal;
    logic              full;
    logic              empty;
    logic              push;
    logic              pop;
    logic              wr_en;

    always_comb begin
        word = '0;
        illegal = 1'b0;
        case (in_iop)
            5'd0:  word = {6'h00, in_rs, in_rt, in_rd, 5'd0, 6'h20};
            5'd1:  word = {6'h00, in_rs, in_rt, in_rd, 5'd0, 6'h22};
            5'd2:  word = {6'h00, in_rs, in_rt, in_rd, 5'd0, 6'h24};
            5'd3:  word = {6'h00, in_rs, in_rt, in_rd, 5'd0, 6'h25};
            5'd4:  word = {6'h00, in_rs, in_rt, in_rd, 5'd0, 6'h26};
            5'd5:  word = {6'h00, 5'd0, in_rt, in_rd, in_sa, 6'h00};
            5'd6:  word = {6'h00, 5'd0, in_rt, in_rd, in_sa, 6'h02};
            5'd7:  word = {6'h00, 5'd0, in_rt, in_rd, in_sa, 6'h03};
            5'd8:  word = {6'h00, in_rs, 15'd0, 6'h08};
            5'd9:  word = {6'h08, in_rs, in_rt, in_imm};
            5'd10: word = {6'h0C, in_rs, in_rt, in_imm};
            5'd11: word = {6'h0D, in_rs, in_rt, in_imm};
            5'd12: word = {6'h0E, in_rs, in_rt, in_imm};
            5'd13: word = {6'h23, in_rs, in_rt, in_imm};
            5'd14: word = {6'h2B, in_rs, in_rt, in_imm};
            5'd15: word = {6'h04, in_rs, in_rt, in_imm};
            5'd16: word = {6'h05, in_rs, in_rt, in_imm};
            5'd17: word = {6'h0F, 5'd0, in_rt, in_imm};
            5'd18: word = {6'h02, in_target};
            5'd19: word = {6'h03, in_target};
            default: illegal = 1'b1;
        endcase
    end

    assign empty = (wr_ptr == rd_ptr);
    assign full = (wr_ptr[PW] != rd_ptr[PW]) &&
                  (wr_ptr[PW-1:0] == rd_ptr[PW-1:0]);
    assign in_ready = !full;
    assign out_valid = !empty;
    assign push = in_valid && in_ready;
    assign pop = out_valid && out_ready;
    assign out_word = empty ? 32'd0 : mem[rd_ptr[PW-1:0]];
    assign out_addr = addr;

`ifdef ENC_ILLEGAL_TRAP_EN
    logic err_q;

    assign wr_en = push && !illegal;
    assign err = err_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            err_q <= 1'b0;
        end else if (flush) begin
            err_q <= 1'b0;
        end else if (push && illegal) begin
            err_q <= 1'b1;
        end
    end
`else
    // Illegal codes fall through as the all-zero nop word.
    assign wr_en = push;
    assign err = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (wr_en && !flush) begin
            mem[wr_ptr[PW-1:0]] <= word;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            addr <= BASE_ADDR;
        end else if (flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            addr <= BASE_ADDR;
        end else begin
            if (wr_en) begin
                wr_ptr <= wr_ptr + (PW+1)'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + (PW+1)'(1);
                addr <= addr + ADDR_W'(1);
            end
        end
    end
endmodule
